// File: rtl/axil_master_cmd.sv
// Accepts one read/write command at a time and runs it as an AXI4-Lite transaction.
// Optional watchdog enabled by defining AXIL_MASTER_CMD_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module axil_master_cmd #(
    parameter int         DATA_WIDTH     = 32,
    parameter int         ADDR_WIDTH     = 16,
    parameter int         STRB_WIDTH     = DATA_WIDTH/8,
    parameter logic [2:0] PROT           = 3'b000,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    input  logic                  cmd_we,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_is_write,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axil_master_cmd: TIMEOUT_CYCLES must be >= 2");
    end

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] awaddr_n, araddr_n;
    logic [DATA_WIDTH-1:0] wdata_n, rsp_rdata_n;
    logic [STRB_WIDTH-1:0] wstrb_n;
    logic                  awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
    logic [1:0]            rsp_resp_n;
    logic                  rsp_is_write_n, rsp_valid_n;

`ifdef AXIL_MASTER_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             active;
    assign active = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_RESP);
`endif

    assign cmd_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign m_axil_awprot = PROT;
    assign m_axil_arprot = PROT;

    always_comb begin
        state_n        = state;
        awaddr_n       = m_axil_awaddr;
        araddr_n       = m_axil_araddr;
        wdata_n        = m_axil_wdata;
        wstrb_n        = m_axil_wstrb;
        awvalid_n      = m_axil_awvalid;
        wvalid_n       = m_axil_wvalid;
        bready_n       = m_axil_bready;
        arvalid_n      = m_axil_arvalid;
        rready_n       = m_axil_rready;
        rsp_rdata_n    = rsp_rdata;
        rsp_resp_n     = rsp_resp;
        rsp_is_write_n = rsp_is_write;
        rsp_valid_n    = rsp_valid;
        case (state)
            IDLE: if (cmd_valid) begin
                bready_n = 1'b0;
                rready_n = 1'b0;
                if (cmd_we) begin
                    awaddr_n  = cmd_addr;
                    wdata_n   = cmd_wdata;
                    wstrb_n   = cmd_wstrb;
                    awvalid_n = 1'b1;
                    wvalid_n  = 1'b1;
                    state_n   = WR_REQ;
                end else begin
                    araddr_n  = cmd_addr;
                    arvalid_n = 1'b1;
                    state_n   = RD_REQ;
                end
            end
            // AW and W complete independently; a channel is done once its valid is low.
            WR_REQ: begin
                awvalid_n = m_axil_awvalid && !m_axil_awready;
                wvalid_n  = m_axil_wvalid && !m_axil_wready;
                if (!awvalid_n && !wvalid_n) begin
                    bready_n = 1'b1;
                    state_n  = WR_RESP;
                end
            end
            WR_RESP: if (m_axil_bvalid) begin
                bready_n       = 1'b0;
                rsp_valid_n    = 1'b1;
                rsp_is_write_n = 1'b1;
                rsp_rdata_n    = '0;
                rsp_resp_n     = m_axil_bresp;
                state_n        = RSP;
            end
            RD_REQ: if (m_axil_arready) begin
                arvalid_n = 1'b0;
                rready_n  = 1'b1;
                state_n   = RD_RESP;
            end
            RD_RESP: if (m_axil_rvalid) begin
                rready_n       = 1'b0;
                rsp_valid_n    = 1'b1;
                rsp_is_write_n = 1'b0;
                rsp_rdata_n    = m_axil_rdata;
                rsp_resp_n     = m_axil_rresp;
                state_n        = RSP;
            end
            RSP: if (rsp_ready) begin
                rsp_valid_n = 1'b0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
`ifdef AXIL_MASTER_CMD_TIMEOUT_EN
        cnt_n = cnt;
        if (state == IDLE && cmd_valid)
            cnt_n = '0;
        else if (active)
            cnt_n = cnt + 1'b1;
        if (active && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            awvalid_n      = 1'b0;
            wvalid_n       = 1'b0;
            arvalid_n      = 1'b0;
            rsp_valid_n    = 1'b1;
            rsp_resp_n     = 2'b11;
            rsp_rdata_n    = '0;
            rsp_is_write_n = (state == WR_REQ) || (state == WR_RESP);
            state_n        = RSP;
        end
        // Soak up late B/R beats left behind by an abandoned transaction.
        if (state_n == RSP || state_n == IDLE) begin
            bready_n = 1'b1;
            rready_n = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            m_axil_awaddr  <= '0;
            m_axil_araddr  <= '0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= 2'b00;
            rsp_is_write   <= 1'b0;
            rsp_valid      <= 1'b0;
`ifdef AXIL_MASTER_CMD_TIMEOUT_EN
            cnt            <= '0;
`endif
        end else begin
            state          <= state_n;
            m_axil_awaddr  <= awaddr_n;
            m_axil_araddr  <= araddr_n;
            m_axil_wdata   <= wdata_n;
            m_axil_wstrb   <= wstrb_n;
            m_axil_awvalid <= awvalid_n;
            m_axil_wvalid  <= wvalid_n;
            m_axil_bready  <= bready_n;
            m_axil_arvalid <= arvalid_n;
            m_axil_rready  <= rready_n;
            rsp_rdata      <= rsp_rdata_n;
            rsp_resp       <= rsp_resp_n;
            rsp_is_write   <= rsp_is_write_n;
            rsp_valid      <= rsp_valid_n;
`ifdef AXIL_MASTER_CMD_TIMEOUT_EN
            cnt            <= cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_axil_master_cmd.sv
// Bench for axil_master_cmd: random-delay AXI-Lite slave plus a memory reference model.
// The watchdog section runs only when AXIL_MASTER_CMD_TIMEOUT_EN is defined.
module tb_axil_master_cmd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        cmd_we = 1'b0, cmd_valid = 1'b0, cmd_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_is_write, rsp_valid, rsp_ready = 1'b0, busy;
    logic [15:0] m_axil_awaddr, m_axil_araddr;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic        m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
    logic [31:0] m_axil_wdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_awready = 1'b0, m_axil_wready = 1'b0, m_axil_bvalid = 1'b0;
    logic        m_axil_arready = 1'b0, m_axil_rvalid = 1'b0;
    logic [1:0]  m_axil_bresp = '0, m_axil_rresp = '0;
    logic [31:0] m_axil_rdata = '0;

    always #5 clk = ~clk;

    axil_master_cmd #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .PROT(3'b000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_we(cmd_we),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_is_write(rsp_is_write),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .busy(busy),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // slave memory (fed from bus beats) and reference memory (fed from commands)
    logic [31:0] smem [256];
    logic [31:0] rmem [256];

    int aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, rsp_cnt;
    int n_aw, n_w, n_b, n_ar, n_r, t;
    int aw_first, aw_last, w_first, w_last, ar_first, ar_last, rsp_first;
    bit aw_got, w_got, ar_got, b_done, r_done, rsp_got;
    logic [15:0] c_awaddr, c_araddr, p_awaddr, p_araddr;
    logic [31:0] c_wdata, p_wdata, c_rdata, p_rsp_rdata;
    logic [3:0]  c_wstrb, p_wstrb;
    logic [1:0]  c_resp, p_rsp_resp;
    logic        c_isw, p_rsp_is_write;
    logic        p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready, p_rsp_valid;

    // address map of the modelled slave: bit15 selects an error region, bit14 picks DECERR
    function automatic logic [1:0] resp_of(input logic [15:0] a);
        return a[15] ? (a[14] ? 2'b11 : 2'b10) : 2'b00;
    endfunction

    function automatic logic [31:0] err_data(input logic [15:0] a);
        return 32'hBAD0_0000 | {16'h0, a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic set_dly(input int a, input int w, input int b, input int ar, input int r, input int rs);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r; rsp_dly = rs;
    endtask

    task automatic slave_clear();
        aw_got = 0; w_got = 0; ar_got = 0; b_done = 0; r_done = 0; rsp_got = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; rsp_cnt = 0;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; t = 0;
        aw_first = -1; aw_last = -1; w_first = -1; w_last = -1;
        ar_first = -1; ar_last = -1; rsp_first = -1;
        m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0;
        m_axil_arready = 0; m_axil_rvalid = 0; rsp_ready = 0;
    endtask

    // One cycle: resolve handshakes of the last rising edge, monitor, then drive the slave.
    task automatic tick();
        @(negedge clk);
        t++;
        if (p_awvalid === 1'b1 && m_axil_awready) begin n_aw++; aw_got = 1; c_awaddr = p_awaddr; end
        if (p_wvalid === 1'b1 && m_axil_wready) begin n_w++; w_got = 1; c_wdata = p_wdata; c_wstrb = p_wstrb; end
        if (m_axil_bvalid && p_bready === 1'b1) begin n_b++; m_axil_bvalid = 0; b_done = 1; end
        if (p_arvalid === 1'b1 && m_axil_arready) begin n_ar++; ar_got = 1; c_araddr = p_araddr; end
        if (m_axil_rvalid && p_rready === 1'b1) begin n_r++; m_axil_rvalid = 0; r_done = 1; end
        if (p_rsp_valid === 1'b1 && rsp_ready) begin
            rsp_got = 1; c_rdata = p_rsp_rdata; c_resp = p_rsp_resp; c_isw = p_rsp_is_write;
        end
        if (p_rsp_valid === 1'b1 && !rsp_ready) begin
            check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
            check("rsp_hold_rdata", 64'(rsp_rdata), 64'(p_rsp_rdata));
            check("rsp_hold_resp", 64'(rsp_resp), 64'(p_rsp_resp));
            check("rsp_hold_isw", 64'(rsp_is_write), 64'(p_rsp_is_write));
        end
        if (rsp_valid === 1'b1) check("cmd_ready_in_rsp", 64'(cmd_ready), 64'd0);
        if (m_axil_awvalid === 1'b1) begin if (aw_first < 0) aw_first = t; aw_last = t; end
        if (m_axil_wvalid === 1'b1) begin if (w_first < 0) w_first = t; w_last = t; end
        if (m_axil_arvalid === 1'b1) begin if (ar_first < 0) ar_first = t; ar_last = t; end
        if (rsp_valid === 1'b1 && rsp_first < 0) rsp_first = t;
        p_awvalid = m_axil_awvalid; p_wvalid = m_axil_wvalid; p_bready = m_axil_bready;
        p_arvalid = m_axil_arvalid; p_rready = m_axil_rready; p_rsp_valid = rsp_valid;
        p_awaddr = m_axil_awaddr; p_araddr = m_axil_araddr; p_wdata = m_axil_wdata; p_wstrb = m_axil_wstrb;
        p_rsp_rdata = rsp_rdata; p_rsp_resp = rsp_resp; p_rsp_is_write = rsp_is_write;
        m_axil_awready = 0;
        if (m_axil_awvalid === 1'b1 && !aw_got) begin if (aw_cnt >= aw_dly) m_axil_awready = 1; else aw_cnt++; end
        m_axil_wready = 0;
        if (m_axil_wvalid === 1'b1 && !w_got) begin if (w_cnt >= w_dly) m_axil_wready = 1; else w_cnt++; end
        m_axil_arready = 0;
        if (m_axil_arvalid === 1'b1 && !ar_got) begin if (ar_cnt >= ar_dly) m_axil_arready = 1; else ar_cnt++; end
        if (aw_got && w_got && !b_done && !m_axil_bvalid) begin
            if (b_cnt >= b_dly) begin
                m_axil_bvalid = 1;
                m_axil_bresp = resp_of(c_awaddr);
                if (m_axil_bresp == 2'b00) smem[c_awaddr[9:2]] = merge(smem[c_awaddr[9:2]], c_wdata, c_wstrb);
            end else b_cnt++;
        end
        if (ar_got && !r_done && !m_axil_rvalid) begin
            if (r_cnt >= r_dly) begin
                m_axil_rvalid = 1;
                m_axil_rresp = resp_of(c_araddr);
                m_axil_rdata = (m_axil_rresp == 2'b00) ? smem[c_araddr[9:2]] : err_data(c_araddr);
            end else r_cnt++;
        end
        rsp_ready = 0;
        if (rsp_valid === 1'b1 && !rsp_got) begin if (rsp_cnt >= rsp_dly) rsp_ready = 1; else rsp_cnt++; end
    endtask

    task automatic start_cmd(input bit we, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin tick(); k++; end
        if (cmd_ready !== 1'b1) check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        slave_clear();
        cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        tick();
        cmd_valid = 0; cmd_addr = 16'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    endtask

    task automatic wait_rsp();
        int k;
        k = 0;
        while (!rsp_got && k < 200) begin tick(); k++; end
        if (!rsp_got) check("rsp_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic do_cmd(input bit we, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] er;
        start_cmd(we, a, d, s);
        wait_rsp();
        check("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
        check("rsp_valid_after_rsp", 64'(rsp_valid), 64'd0);
        er = resp_of(a);
        check("rsp_resp", 64'(c_resp), 64'(er));
        check("rsp_is_write", 64'(c_isw), 64'(we));
        if (we) begin
            check("wr_beats", 64'({n_aw[3:0], n_w[3:0], n_b[3:0], n_ar[3:0]}), 64'h1110);
            check("awaddr", 64'(c_awaddr), 64'(a));
            check("wdata_wstrb", 64'({c_wdata, c_wstrb}), 64'({d, s}));
            check("wr_rdata", 64'(c_rdata), 64'd0);
            if (er == 2'b00) rmem[a[9:2]] = merge(rmem[a[9:2]], d, s);
        end else begin
            check("rd_beats", 64'({n_ar[3:0], n_r[3:0], n_aw[3:0], n_w[3:0]}), 64'h1100);
            check("araddr", 64'(c_araddr), 64'(a));
            check("rd_rdata", 64'(c_rdata), 64'((er == 2'b00) ? rmem[a[9:2]] : err_data(a)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin smem[i] = '0; rmem[i] = '0; end
        set_dly(0, 0, 0, 0, 0, 0);
        slave_clear();
        repeat (3) tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_ctrl", 64'({busy, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
                              m_axil_arvalid, m_axil_rready, rsp_valid}), 64'd0);
        check("rst_rsp", 64'({rsp_rdata, rsp_resp, rsp_is_write}), 64'd0);
        check("rst_payload", 64'({m_axil_awaddr, m_axil_araddr, m_axil_wstrb}), 64'd0);
        check("rst_wdata", 64'(m_axil_wdata), 64'd0);
        check("prot", 64'({m_axil_awprot, m_axil_arprot}), 64'd0);
        rst = 0;
        tick();

        // zero-wait write then read-back
        do_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
        check("wr_aw_first", 64'(aw_first), 64'd1);
        check("wr_w_first", 64'(w_first), 64'd1);
        check("wr_rsp_first", 64'(rsp_first), 64'd3);
`ifdef AXIL_MASTER_CMD_TIMEOUT_EN
        check("idle_bready", 64'({m_axil_bready, m_axil_rready}), 64'd3);
`else
        check("idle_bready", 64'({m_axil_bready, m_axil_rready}), 64'd0);
`endif
        do_cmd(1'b0, 16'h0010, 32'h0, 4'h0);
        check("rd_ar_first", 64'(ar_first), 64'd1);
        check("rd_rsp_first", 64'(rsp_first), 64'd3);
        check("rd_deadbeef", 64'(c_rdata), 64'hDEADBEEF);

        // W accepted three cycles ahead of AW
        set_dly(3, 0, 0, 0, 0, 0);
        do_cmd(1'b1, 16'h0024, 32'h1234_5678, 4'b0101);
        check("w_last", 64'(w_last), 64'd1);
        check("aw_last", 64'(aw_last), 64'd4);

        // SLVERR read with the response stalled five cycles
        set_dly(0, 0, 0, 0, 0, 5);
        do_cmd(1'b0, 16'h8010, 32'h0, 4'h0);
        check("rsp_stall_cycles", 64'(rsp_cnt), 64'd5);
        check("slverr", 64'(c_resp), 64'd2);

        // reset while waiting for B
        set_dly(0, 0, 8, 0, 0, 0);
        start_cmd(1'b1, 16'h0040, 32'hCAFEF00D, 4'hF);
        tick();
        check("in_wr_resp", 64'({m_axil_bready, busy}), 64'd3);
        rst = 1;
        tick();
        check("rst_mid_bready", 64'(m_axil_bready), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        rst = 0;
        slave_clear();
        tick();

`ifdef AXIL_MASTER_CMD_TIMEOUT_EN
        // slave never accepts AR: watchdog closes the transaction with DECERR
        set_dly(0, 0, 0, 1000000, 0, 0);
        start_cmd(1'b0, 16'h0020, 32'h0, 4'h0);
        wait_rsp();
        check("to_ar_first", 64'(ar_first), 64'd1);
        check("to_ar_last", 64'(ar_last), 64'd16);
        check("to_resp", 64'(c_resp), 64'd3);
        check("to_rdata", 64'(c_rdata), 64'd0);
        check("to_isw", 64'(c_isw), 64'd0);
        check("to_idle_ready", 64'({m_axil_bready, m_axil_rready, m_axil_arvalid}), 64'b110);
`endif

        // randomized mix of reads/writes, strobes, error regions and slave delays
        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 15) << 2) | 16'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin a[15] = 1'b1; a[14] = 1'($urandom_range(0, 1)); end
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            do_cmd(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
